// File: rtl/mac_chain_drain_pkg.sv
// Shared defaults and types for the MAC chain drain block and its requantizer.
package mac_chain_drain_pkg;

    localparam int ACC_W = 32;
    localparam int ACT_W = 8;
    localparam int LANES = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    // Lane-index width; a single-lane chain still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mac_chain_drain_if.sv
// Capture and output-beat handshake bundle between the MAC chain, the drain and the activation buffer.
interface mac_chain_drain_if
    import mac_chain_drain_pkg::*;
#(
    parameter int size      = LANES,
    parameter int acc_width = ACC_W,
    parameter int out_width = ACT_W
) ();

    localparam int IDX_W = idx_width(size);

    logic [size*acc_width-1:0] acc_in;
    logic                      acc_valid;
    logic                      acc_ready;
    logic [out_width-1:0]      out_data;
    logic [IDX_W-1:0]          out_index;
    logic                      out_sat;
    logic                      out_last;
    logic                      out_valid;
    logic                      out_ready;

    modport slave (
        input  acc_in, acc_valid, out_ready,
        output acc_ready, out_data, out_index, out_sat, out_last, out_valid
    );

    modport master (
        output acc_in, acc_valid, out_ready,
        input  acc_ready, out_data, out_index, out_sat, out_last, out_valid
    );

endinterface

// File: rtl/mac_chain_drain_requant_sat.sv
// Requantizer: round-half-up shift, optional ReLU, signed saturation to out_width.
// Latency: purely combinational.
// Backpressure: none, no state.
module requant_sat #(
    parameter int acc_width = 32,
    parameter int out_width = 8,
    parameter int shift     = 0,
    parameter bit relu      = 1'b0
) (
    input  logic signed [acc_width-1:0] x_i,
    output logic signed [out_width-1:0] data_o,
    output logic                        sat_o
);

    // One guard bit so adding the rounding constant cannot wrap.
    localparam int W = acc_width + 1;
    localparam logic signed [W-1:0] RND     = W'((64'(1) << shift) >> 1);
    localparam logic signed [W-1:0] SAT_MAX = {{(W-out_width+1){1'b0}}, {(out_width-1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = {{(W-out_width+1){1'b1}}, {(out_width-1){1'b0}}};

    logic signed [W-1:0] ext_d;
    logic signed [W-1:0] rnd_d;
    logic signed [W-1:0] shf_d;
    logic signed [W-1:0] v_d;

    always_comb begin
        ext_d  = {x_i[acc_width-1], x_i};
        rnd_d  = ext_d + RND;
        shf_d  = rnd_d >>> shift;
        v_d    = (relu && shf_d[W-1]) ? '0 : shf_d;
        sat_o  = 1'b0;
        data_o = v_d[out_width-1:0];
        if (v_d > SAT_MAX) begin
            sat_o  = 1'b1;
            data_o = SAT_MAX[out_width-1:0];
        end else if (v_d < SAT_MIN) begin
            sat_o  = 1'b1;
            data_o = SAT_MIN[out_width-1:0];
        end
    end

endmodule

// File: rtl/mac_chain_drain.sv
// Captures a packed accumulator vector and streams it out one requantized lane per beat.
// Latency: first beat the cycle after capture; size beats with out_ready held high.
// Backpressure: beats hold stable while out_ready=0; acc_ready only in IDLE (1-cycle bubble).
module mac_chain_drain
    import mac_chain_drain_pkg::*;
#(
    parameter int size      = LANES,
    parameter int acc_width = ACC_W,
    parameter int out_width = ACT_W,
    parameter int shift     = 0,
    parameter bit relu      = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    mac_chain_drain_if.slave bus
);

    localparam int IDX_W = idx_width(size);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(size - 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  cap_en;
    logic                  is_last;
    logic [acc_width-1:0]  cap_q [size];

    logic signed [out_width-1:0] rq_data;
    logic                        rq_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Capture buffer carries no reset; it is only read while DRAIN.
    always_ff @(posedge clk) begin
        if (cap_en) begin
            for (int k = 0; k < size; k++) begin
                cap_q[k] <= bus.acc_in[k*acc_width +: acc_width];
            end
        end
    end

    requant_sat #(
        .acc_width (acc_width),
        .out_width (out_width),
        .shift     (shift),
        .relu      (relu)
    ) u_requant (
        .x_i    (cap_q[idx_q]),
        .data_o (rq_data),
        .sat_o  (rq_sat)
    );

    assign is_last = (state_q == ST_DRAIN) && (idx_q == LAST_IDX);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cap_en        = 1'b0;
        bus.acc_ready = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_index = idx_q;
        bus.out_last  = is_last;
        bus.out_data  = '0;
        bus.out_sat   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                bus.acc_ready = 1'b1;
                if (bus.acc_valid && !rst) begin
                    cap_en  = 1'b1;
                    idx_d   = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                bus.out_valid = 1'b1;
                bus.out_data  = rq_data;
                bus.out_sat   = rq_sat;
                if (bus.out_ready) begin
                    if (is_last) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mac_chain_drain.sv
// Directed bench for mac_chain_drain with a beat scoreboard; covers shift/ReLU and single-lane variants.
module tb_mac_chain_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [127:0] acc_in;
    logic         acc_valid;
    logic         out_ready;
    logic         sel;
    logic [31:0]  acc_in2;
    logic         acc_valid2;
    logic         out_ready2;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       sat;
        logic       last;
        logic [1:0] idx;
    } beat_t;

    beat_t q[$];

    mac_chain_drain_if #(.size(4), .acc_width(32), .out_width(8)) if0 ();
    mac_chain_drain_if #(.size(4), .acc_width(32), .out_width(8)) if1 ();
    mac_chain_drain_if #(.size(1), .acc_width(32), .out_width(8)) if2 ();

    mac_chain_drain #(.size(4), .acc_width(32), .out_width(8), .shift(0), .relu(1'b0))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    mac_chain_drain #(.size(4), .acc_width(32), .out_width(8), .shift(2), .relu(1'b1))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    mac_chain_drain #(.size(1), .acc_width(32), .out_width(8), .shift(0), .relu(1'b0))
        u2 (.clk(clk), .rst(rst), .bus(if2));

    assign if0.acc_in    = acc_in;
    assign if0.acc_valid = acc_valid;
    assign if0.out_ready = out_ready;
    assign if1.acc_in    = acc_in;
    assign if1.acc_valid = acc_valid;
    assign if1.out_ready = out_ready;
    assign if2.acc_in    = acc_in2;
    assign if2.acc_valid = acc_valid2;
    assign if2.out_ready = out_ready2;

    logic [7:0]  o_data;
    logic        o_sat, o_last, o_valid, o_acc_ready;
    logic [1:0]  o_index;
    logic [11:0] cur;
    assign o_data      = sel ? if1.out_data  : if0.out_data;
    assign o_sat       = sel ? if1.out_sat   : if0.out_sat;
    assign o_last      = sel ? if1.out_last  : if0.out_last;
    assign o_valid     = sel ? if1.out_valid : if0.out_valid;
    assign o_index     = sel ? if1.out_index : if0.out_index;
    assign o_acc_ready = sel ? if1.acc_ready : if0.acc_ready;
    assign cur         = {o_data, o_sat, o_last, o_index};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t model(input logic signed [31:0] x, input int k, input int sh, input bit rl);
        longint v;
        beat_t  b;
        v = longint'(x);
        if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
        if (rl && v < 0) v = 0;
        if (v > 127) begin
            b.data = 8'h7f; b.sat = 1'b1;
        end else if (v < -128) begin
            b.data = 8'h80; b.sat = 1'b1;
        end else begin
            b.data = v[7:0]; b.sat = 1'b0;
        end
        b.last = (k == 3);
        b.idx  = 2'(k);
        return b;
    endfunction

    task automatic push_vec(input logic signed [31:0] a, b, c, d);
        logic signed [31:0] l [4];
        l = '{a, b, c, d};
        for (int k = 0; k < 4; k++) q.push_back(model(l[k], k, sel ? 2 : 0, sel));
        acc_in = {d, c, b, a};
    endtask

    task automatic send(input logic signed [31:0] a, b, c, d);
        logic ok;
        ok = 1'b0;
        push_vec(a, b, c, d);
        acc_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = o_acc_ready;
            @(negedge clk);
        end
        check("send_accepted", ok, 1);
        acc_valid = 1'b0;
    endtask

    // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0 repeating.
    task automatic drain(input int mode, input int nbeats, output int cyc);
        beat_t e, held;
        bit    held_vld;
        int    popped;
        held_vld = 1'b0;
        held     = '0;
        popped   = 0;
        cyc      = 0;
        while (popped < nbeats && cyc < 60) begin
            out_ready = (mode == 0) || (cyc % 3 == 0);
            if (o_valid) begin
                check("acc_ready_busy", o_acc_ready, 0);
                if (held_vld) check("hold_stable", cur, held);
                if (out_ready) begin
                    e = (q.size() > 0) ? q.pop_front() : '0;
                    check($sformatf("beat_lane%0d", e.idx), cur, e);
                    popped++;
                    held_vld = 1'b0;
                end else begin
                    held     = cur;
                    held_vld = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        check("drain_beats", popped, nbeats);
    endtask

    int cyc;

    initial begin
        sel        = 1'b0;
        rst        = 1'b1;
        acc_in     = '0;
        acc_valid  = 1'b0;
        out_ready  = 1'b0;
        acc_in2    = '0;
        acc_valid2 = 1'b0;
        out_ready2 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_acc_ready", if0.acc_ready, 1);
        check("rst_out_valid", if0.out_valid, 0);
        check("rst_out_last",  if0.out_last, 0);
        check("rst_out_sat",   if0.out_sat, 0);
        check("rst_out_index", if0.out_index, 0);
        check("rst_out_data",  if0.out_data, 0);
        check("rst_size1_rdy", if2.acc_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // basic drain
        send(3, -5, 127, -128);
        drain(0, 4, cyc);
        check("t1_cycles", cyc, 4);
        check("t1_idle_ready", o_acc_ready, 1);
        check("t1_idle_valid", o_valid, 0);

        // saturation
        send(200, -300, 32'h7FFFFFFF, 32'h80000000);
        drain(0, 4, cyc);

        // rounding + relu (shift=2, relu=1 instance)
        sel = 1'b1;
        send(5, 6, -6, 9);
        drain(0, 4, cyc);
        send(1000, -1000, 2, -2);
        drain(0, 4, cyc);
        sel = 1'b0;

        // backpressure
        send(1, -2, 300, -7);
        drain(1, 4, cyc);
        check("t4_cycles", cyc, 10);
        check("t4_idle_ready", o_acc_ready, 1);

        // back-to-back: second vector presented during drain
        send(11, 22, 33, 44);
        push_vec(-1, -2, -3, -4);
        acc_valid = 1'b1;
        drain(0, 4, cyc);
        check("t5_first_cycles", cyc, 4);
        check("t5_bubble_valid", o_valid, 0);
        check("t5_bubble_ready", o_acc_ready, 1);
        @(negedge clk);
        acc_valid = 1'b0;
        drain(0, 4, cyc);
        check("t5_second_cycles", cyc, 4);

        // reset mid-drain
        send(7, 8, 9, 10);
        drain(0, 1, cyc);
        check("t6_lane1_shown", o_index, 1);
        check("t6_valid_before", o_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_valid_after", o_valid, 0);
        check("t6_ready_after", o_acc_ready, 1);
        check("t6_index_after", o_index, 0);
        q.delete();
        send(-20, 21, -22, 23);
        drain(0, 4, cyc);
        check("t6_redrain_cycles", cyc, 4);

        // single-lane instance
        out_ready  = 1'b0;
        acc_in2    = 32'd1000;
        acc_valid2 = 1'b1;
        check("s1_ready", if2.acc_ready, 1);
        @(negedge clk);
        acc_valid2 = 1'b0;
        check("s1_valid", if2.out_valid, 1);
        check("s1_last",  if2.out_last, 1);
        check("s1_index", if2.out_index, 0);
        check("s1_data",  if2.out_data, 8'h7f);
        check("s1_sat",   if2.out_sat, 1);
        @(negedge clk);
        check("s1_hold_data", if2.out_data, 8'h7f);
        out_ready2 = 1'b1;
        @(negedge clk);
        check("s1_done_valid", if2.out_valid, 0);
        check("s1_done_ready", if2.acc_ready, 1);
        out_ready2 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
